pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_sequencer_ras_stack.sv | 61 ++++++
 rtl/pc_sequencer.sv | 96 +++++++++
 tb/tb_pc_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op encoding and default sizing.
package pc_seq_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_STEP      = 4;
  localparam int DEFAULT_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_HOLD   = 3'd5
  } op_t;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: a write pointer plus a saturating count.
// When the stack is full, a push overwrites the oldest entry.
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_RAS_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW:0]      count_q, count_d;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign top_data = mem_q[ptr_q - PTR_ONE];

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      ptr_d = ptr_q + PTR_ONE;
      if (!full) count_d = count_q + CNT_ONE;
    end else if (pop && !empty) begin
      ptr_d   = ptr_q - PTR_ONE;
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset on purpose; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential step, jump, relative branch and call/return
// through a circular return-address stack. pc is purely registered.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                   WIDTH        = DEFAULT_WIDTH,
  parameter int                   STEP         = DEFAULT_STEP,
  parameter logic [WIDTH-1:0]     RESET_VECTOR = '0,
  parameter int                   RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic [2:0]                    op,
  input  logic [WIDTH-1:0]              target,
  output logic [WIDTH-1:0]              pc,
  output logic [$clog2(RAS_DEPTH):0]    ras_count,
  output logic                          ras_overflow,
  output logic                          ras_underflow
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push, pop, full, empty;
  logic [WIDTH-1:0] top_data;
  op_t              op_e;

  assign op_e = op_t'(op);

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_q + STEP_W),
    .top_data  (top_data),
    .count     (ras_count),
    .full      (full),
    .empty     (empty)
  );

  // NOTE: every signal gets a default before the case so no latch can be inferred.
  always_comb begin
    pc_d  = pc_q;
    push  = 1'b0;
    pop   = 1'b0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (!stall) begin
      unique case (op_e)
        OP_HOLD:   pc_d = pc_q;
        OP_JUMP:   pc_d = target;
        OP_BRANCH: pc_d = pc_q + target;
        OP_CALL: begin
          push  = 1'b1;
          ovf_d = full;
          pc_d  = target;
        end
        OP_RET: begin
          if (empty) begin
            unf_d = 1'b1;
            pc_d  = pc_q + STEP_W;
          end else begin
            pop  = 1'b1;
            pc_d = top_data;
          end
        end
        default:   pc_d = pc_q + STEP_W;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc            = pc_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized ops,
// compared against a queue-based behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  op;
  logic [31:0] target;
  logic [31:0] pc;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a bounded LIFO of return addresses, oldest at the front.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_unf;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .op            (op),
    .target        (target),
    .pc            (pc),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},  pc, m_pc);
    check({tag, ".cnt"}, 32'(ras_count), 32'(m_ras.size()));
    check({tag, ".ovf"}, 32'(ras_overflow), 32'(m_ovf));
    check({tag, ".unf"}, 32'(ras_underflow), 32'(m_unf));
  endtask

  // Called during the low phase; applies inputs, advances the model, checks after the edge,
  // and returns at the following falling edge.
  task automatic do_op(input string tag, input logic st, input logic [2:0] o,
                       input logic [31:0] t);
    stall  = st;
    op     = o;
    target = t;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    if (!st) begin
      case (o)
        3'd1: m_pc = t;
        3'd2: m_pc = m_pc + t;
        3'd3: begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > 4) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_pc = t;
        end
        3'd4: begin
          if (m_ras.size() == 0) begin
            m_pc  = m_pc + 32'd4;
            m_unf = 1'b1;
          end else begin
            m_pc = m_ras.pop_back();
          end
        end
        3'd5: ;
        default: m_pc = m_pc + 32'd4;
      endcase
    end
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  // Reset asserted in the middle of the low phase; pc must clear before any edge.
  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    check("rst.pc_async", pc, 32'h0);
    check("rst.cnt_async", 32'(ras_count), 32'h0);
    check("rst.flags_async", {30'h0, ras_overflow, ras_underflow}, 32'h0);
    @(posedge clk);
    #1;
    check("rst.pc_held", pc, 32'h0);
    m_pc = 32'h0;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    stall  = 1'b0;
    op     = 3'd3;
    target = 32'h1234;
    m_pc   = 32'h0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.pc", pc, 32'h0);
    check("reset.cnt", 32'(ras_count), 32'h0);
    check("reset.ovf", 32'(ras_overflow), 32'h0);
    check("reset.unf", 32'(ras_underflow), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Sequential stepping, then asynchronous reset mid-clock.
    for (int i = 0; i < 3; i++) do_op("next", 1'b0, 3'd0, 32'h0);
    check("next3.pc", pc, 32'hC);
    mid_reset();

    // Relative branch backwards, jump, and wrap at the top of the address space.
    do_op("jmp100", 1'b0, 3'd1, 32'h100);
    do_op("branch", 1'b0, 3'd2, 32'hFFFF_FFF0);
    check("branch.pc", pc, 32'hF0);
    do_op("jmp2000", 1'b0, 3'd1, 32'h2000);
    check("jmp2000.pc", pc, 32'h2000);
    do_op("jmptop", 1'b0, 3'd1, 32'hFFFF_FFFC);
    do_op("wrap", 1'b0, 3'd0, 32'h0);
    check("wrap.pc", pc, 32'h0);

    // Single call and return.
    do_op("jmp10", 1'b0, 3'd1, 32'h10);
    do_op("call1", 1'b0, 3'd3, 32'h400);
    check("call1.pc", pc, 32'h400);
    check("call1.cnt", 32'(ras_count), 32'h1);
    do_op("ret1", 1'b0, 3'd4, 32'h0);
    check("ret1.pc", pc, 32'h14);
    check("ret1.cnt", 32'(ras_count), 32'h0);

    // Five nested calls overflow the 4-entry stack, then unwind past empty.
    do_op("jmp0", 1'b0, 3'd1, 32'h0);
    for (int i = 0; i < 5; i++) begin
      do_op("nest_call", 1'b0, 3'd3, 32'((i + 1) * 32'h100));
      check("nest_call.ovf", 32'(ras_overflow), (i == 4) ? 32'h1 : 32'h0);
    end
    check("nest.cnt_full", 32'(ras_count), 32'h4);
    for (int i = 0; i < 4; i++) begin
      do_op("nest_ret", 1'b0, 3'd4, 32'h0);
      check("nest_ret.pc", pc, 32'((4 - i) * 32'h100 + 32'h4));
      check("nest_ret.unf", 32'(ras_underflow), 32'h0);
    end
    do_op("nest_ret5", 1'b0, 3'd4, 32'h0);
    check("nest_ret5.unf", 32'(ras_underflow), 32'h1);
    check("nest_ret5.pc", pc, 32'h108);
    do_op("after_unf", 1'b0, 3'd5, 32'h0);
    check("after_unf.unf", 32'(ras_underflow), 32'h0);

    // Stall holds a pending CALL; it executes exactly once when released.
    do_op("jmp800", 1'b0, 3'd1, 32'h800);
    for (int i = 0; i < 3; i++) do_op("stall_call", 1'b1, 3'd3, 32'h900);
    check("stall.pc", pc, 32'h800);
    check("stall.cnt", 32'(ras_count), 32'h0);
    do_op("unstall_call", 1'b0, 3'd3, 32'h900);
    check("unstall.cnt", 32'(ras_count), 32'h1);
    do_op("unstall_hold", 1'b0, 3'd5, 32'h0);
    check("unstall_hold.cnt", 32'(ras_count), 32'h1);

    // Reset discards stacked returns; the first op after reset runs from pc 0.
    do_op("pre_rst_call", 1'b0, 3'd3, 32'hA00);
    mid_reset();
    do_op("post_rst_ret", 1'b0, 3'd4, 32'h0);
    check("post_rst_ret.unf", 32'(ras_underflow), 32'h1);
    check("post_rst_ret.pc", pc, 32'h4);

    // Randomized ops with occasional stalls and resets.
    for (int n = 0; n < 600; n++) begin
      logic [2:0]  r_op;
      logic [31:0] r_t;
      logic        r_st;
      r_op = 3'($urandom_range(0, 7));
      r_st = ($urandom_range(0, 7) == 0);
      r_t  = $urandom();
      if (r_op == 3'd2 && $urandom_range(0, 1) == 1) r_t = 32'($signed(12'($urandom())));
      if ($urandom_range(0, 79) == 0) mid_reset();
      else do_op("rand", r_st, r_op, r_t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
